// File: rtl/bell_pkg.sv
// Shared definitions for the bell-game datapath.
//   - FSM state encoding used by card_dealer (3-bit)
//   - card field widths (colour CW, number NW)
//   - player key codes
//   - num_lut(): maps a 3-bit LFSR field onto a card number 1..5
package bell_pkg;

    localparam int unsigned CW = 2;
    localparam int unsigned NW = 3;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE = 3'd0;
    localparam state_t S_DEAL = 3'd1;
    localparam state_t S_SHOW = 3'd2;
    localparam state_t S_HOLD = 3'd3;
    localparam state_t S_END  = 3'd4;

    localparam logic [3:0] KEY_P1 = 4'b0111;
    localparam logic [3:0] KEY_P2 = 4'b1001;

    // 8 codes onto 5 numbers; 1..3 appear twice as often as 4 and 5.
    function automatic logic [NW-1:0] num_lut(input logic [2:0] k);
        logic [NW-1:0] n;
        case (k)
            3'd0, 3'd5: n = 3'd1;
            3'd1, 3'd6: n = 3'd2;
            3'd2, 3'd7: n = 3'd3;
            3'd3:       n = 3'd4;
            default:    n = 3'd5;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/card_lfsr.sv
// Free-running 16-bit Fibonacci LFSR (taps 16,14,13,11), advancing every clock.
// Ports:
//   clk  in   clock
//   rst  in   synchronous active-low reset, loads SEED
//   lfsr out  current register value
module card_lfsr
    import bell_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] lfsr
);

    logic [15:0] lfsr_q, lfsr_d;

    always_comb begin
        lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign lfsr = lfsr_q;

endmodule

// File: rtl/card_dealer.sv
// Card dealer: deals a pseudo-random card pair plus a decaying reaction score each round,
// freezes for a hold period after a round is resolved, and ends the game after ROUNDS deals.
// Ports:
//   clk, rst          clock, synchronous active-low reset
//   start             begin a game (only honoured in IDLE)
//   finish            round resolved; moves SHOW to HOLD
//   c1, c2 / n1, n2   card colours 0..3 / numbers 1..5
//   count             reaction score, decremented once per tick while shown
//   card_valid        high while the pair is live
//   deal_no           deals issued in the current game
//   game_over         one-cycle pulse at game end
// All outputs come straight from flops.
module card_dealer
    import bell_pkg::*;
#(
    parameter int unsigned TICK_DIV   = 1000,
    parameter logic [7:0]  COUNT_MAX  = 8'd100,
    parameter int unsigned DEAL_TICKS = 30,
    parameter int unsigned HOLD_TICKS = 10,
    parameter logic [7:0]  ROUNDS     = 8'd20,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          finish,
    output logic [CW-1:0] c1,
    output logic [CW-1:0] c2,
    output logic [NW-1:0] n1,
    output logic [NW-1:0] n2,
    output logic [7:0]    count,
    output logic          card_valid,
    output logic [7:0]    deal_no,
    output logic          game_over
);

    localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned TW = $clog2(DEAL_TICKS + 1);
    localparam int unsigned HW = $clog2(HOLD_TICKS + 1);

    logic [15:0]   lfsr;
    logic          unused_lfsr;

    state_t        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [TW-1:0] show_q, show_d, show_inc;
    logic [HW-1:0] hold_q, hold_d, hold_inc;
    logic [CW-1:0] c1_q, c1_d, c2_q, c2_d;
    logic [NW-1:0] n1_q, n1_d, n2_q, n2_d;
    logic [7:0]    count_q, count_d;
    logic [7:0]    deal_no_q, deal_no_d;
    logic          card_valid_q, card_valid_d;
    logic          game_over_q, game_over_d;
    logic          tick;
    logic          last_round;

    card_lfsr #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk  (clk),
        .rst  (rst),
        .lfsr (lfsr)
    );

    // Only some LFSR fields feed the card mapping.
    assign unused_lfsr = ^{lfsr[15:13], lfsr[7:5]};

    assign tick       = (presc_q == PW'(TICK_DIV - 1));
    assign show_inc   = show_q + TW'(1);
    assign hold_inc   = hold_q + HW'(1);
    assign last_round = (deal_no_q == ROUNDS);

    always_comb begin
        state_d   = state_q;
        presc_d   = tick ? '0 : presc_q + PW'(1);
        show_d    = show_q;
        hold_d    = hold_q;
        c1_d      = c1_q;
        c2_d      = c2_q;
        n1_d      = n1_q;
        n2_d      = n2_q;
        count_d   = count_q;
        deal_no_d = deal_no_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d   = S_DEAL;
                    deal_no_d = '0;
                end
            end
            S_DEAL: begin
                c1_d      = lfsr[1:0];
                c2_d      = lfsr[9:8];
                n1_d      = num_lut(lfsr[4:2]);
                n2_d      = num_lut(lfsr[12:10]);
                count_d   = COUNT_MAX;
                deal_no_d = deal_no_q + 8'd1;
                presc_d   = '0;
                show_d    = '0;
                hold_d    = '0;
                state_d   = S_SHOW;
            end
            S_SHOW: begin
                // finish beats a same-cycle tick: score is frozen at its pre-tick value.
                if (finish) begin
                    state_d = S_HOLD;
                end else if (tick) begin
                    count_d = (count_q == 8'd0) ? 8'd0 : count_q - 8'd1;
                    show_d  = show_inc;
                    if (show_inc == TW'(DEAL_TICKS)) begin
                        state_d = last_round ? S_END : S_DEAL;
                    end
                end
            end
            S_HOLD: begin
                if (tick) begin
                    hold_d = hold_inc;
                    if (hold_inc == HW'(HOLD_TICKS)) begin
                        state_d = last_round ? S_END : S_DEAL;
                    end
                end
            end
            S_END: begin
                count_d = 8'd0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Registered so the flag tracks the state it describes.
        card_valid_d = (state_d == S_SHOW);
        game_over_d  = (state_d == S_END);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            presc_q      <= '0;
            show_q       <= '0;
            hold_q       <= '0;
            c1_q         <= '0;
            c2_q         <= '0;
            n1_q         <= '0;
            n2_q         <= '0;
            count_q      <= '0;
            deal_no_q    <= '0;
            card_valid_q <= 1'b0;
            game_over_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            presc_q      <= presc_d;
            show_q       <= show_d;
            hold_q       <= hold_d;
            c1_q         <= c1_d;
            c2_q         <= c2_d;
            n1_q         <= n1_d;
            n2_q         <= n2_d;
            count_q      <= count_d;
            deal_no_q    <= deal_no_d;
            card_valid_q <= card_valid_d;
            game_over_q  <= game_over_d;
        end
    end

    assign c1         = c1_q;
    assign c2         = c2_q;
    assign n1         = n1_q;
    assign n2         = n2_q;
    assign count      = count_q;
    assign card_valid = card_valid_q;
    assign deal_no    = deal_no_q;
    assign game_over  = game_over_q;

endmodule
